// File: rtl/sum_acc_if.sv
// sum_acc_if: sample-in and batch-out valid/ready bundle for sum_accumulator
//   in_valid/in_ready/in_sum      : upstream sample stream (unsigned IN_W sums)
//   out_valid/out_ready/out_acc/out_ovf : downstream batch result
//   modport slave  : the accumulator side
//   modport master : the producer/consumer side (testbench or neighbours)
interface sum_acc_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport slave  (input in_valid, in_sum, out_ready,
                    output in_ready, out_valid, out_acc, out_ovf);
    modport master (output in_valid, in_sum, out_ready,
                    input in_ready, out_valid, out_acc, out_ovf);
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT unsigned samples per batch and hands the total downstream
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous batch abort, discards partial sum or held result
//   bus   : sum_acc_if.slave (in_valid/in_ready/in_sum, out_valid/out_ready/out_acc/out_ovf)
//   Build option SUM_ACC_SATURATE_EN: acc clamps to all-ones on carry-out instead of wrapping.
module sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12,
    parameter int COUNT = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    sum_acc_if.slave bus
);
    localparam int CW = $clog2(COUNT + 1);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]     state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           ovf;
    logic           accept;
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] acc_nxt;

    assign accept = bus.in_valid && state == ACCUM;
    assign sum    = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_sum};
`ifdef SUM_ACC_SATURATE_EN
    // once a carry occurs acc sits at all-ones; any later carry keeps it there
    assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear || (state == HOLD && bus.out_ready)) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= acc_nxt;
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(COUNT - 1))
                state <= HOLD;
        end
    end

    // all outputs come straight from state/acc/ovf registers
    assign bus.in_ready  = state == ACCUM;
    assign bus.out_valid = state == HOLD;
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench for sum_accumulator (ACC_W=12 and ACC_W=7 instances)
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_acc[2];
    int   m_cnt[2];
    int   m_ovf[2];
    int   qa[$];
    int   qb[$];

    always #5 clk = ~clk;

    sum_acc_if #(.IN_W(5), .ACC_W(12)) a();
    sum_acc_if #(.IN_W(5), .ACC_W(7))  b();

    sum_accumulator #(.IN_W(5), .ACC_W(12), .COUNT(8)) ua (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(a));
    sum_accumulator #(.IN_W(5), .ACC_W(7),  .COUNT(8)) ub (.clk(clk), .rst_n(rst_n), .clear(1'b0), .bus(b));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int s);
        m_acc[s] = 0;
        m_cnt[s] = 0;
        m_ovf[s] = 0;
    endtask

    // reference: exact integer sum, then wrap or clamp to the instance width
    task automatic model(input int s, input int v);
        int w;
        w = (s == 1) ? 7 : 12;
        m_acc[s] += v;
        if (m_acc[s] >= (1 << w)) begin
            m_ovf[s] = 1;
`ifdef SUM_ACC_SATURATE_EN
            m_acc[s] = (1 << w) - 1;
`else
            m_acc[s] -= (1 << w);
`endif
        end
        m_cnt[s]++;
        if (m_cnt[s] == 8) begin
            if (s == 1) qb.push_back((m_ovf[s] << 16) | m_acc[s]);
            else        qa.push_back((m_ovf[s] << 16) | m_acc[s]);
            model_reset(s);
        end
    endtask

    task automatic send(input int s, input int v);
        logic rdy;
        if (s == 1) begin
            b.in_valid = 1'b1;
            b.in_sum   = 5'(v);
            rdy        = b.in_ready;
        end else begin
            a.in_valid = 1'b1;
            a.in_sum   = 5'(v);
            rdy        = a.in_ready & ~clear;
        end
        @(posedge clk);
        #1;
        if (rdy) model(s, v);
    endtask

    task automatic idle(input int n);
        a.in_valid = 1'b0;
        b.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        int e;
        if (rst_n && !clear && a.out_valid && a.out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_acc", int'(a.out_acc), e & 16'hffff);
                chk("a_ovf", int'(a.out_ovf), e >> 16);
            end
        end
        if (rst_n && b.out_valid && b.out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_acc", int'(b.out_acc), e & 16'hffff);
                chk("b_ovf", int'(b.out_ovf), e >> 16);
            end
        end
    end

    initial begin
        int gap[8] = '{3, 7, 0, 16, 31, 1, 2, 4};
        a.in_valid = 1'b0; a.in_sum = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_sum = '0; b.out_ready = 1'b0;
        model_reset(0);
        model_reset(1);
        #12;
        chk("rst_out_valid", int'(a.out_valid), 0);
        chk("rst_out_acc", int'(a.out_acc), 0);
        chk("rst_out_ovf", int'(a.out_ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", int'(a.in_ready), 1);

        a.out_ready = 1'b1;
        b.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(0, 30);
        chk("pre_last_valid", int'(a.out_valid), 0);
        send(0, 30);
        a.in_valid = 1'b0;
        chk("latency_valid", int'(a.out_valid), 1);
        chk("hold_in_ready", int'(a.in_ready), 0);
        idle(1);
        chk("post_handoff_ready", int'(a.in_ready), 1);
        chk("post_handoff_valid", int'(a.out_valid), 0);

        for (int i = 0; i < 8; i++) send(1, 31);
        idle(2);

        a.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(0, i);
        a.in_sum = 5'd5;
        a.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(a.out_valid), 1);
            chk("bp_acc", int'(a.out_acc), 36);
            chk("bp_in_ready", int'(a.in_ready), 0);
            @(posedge clk);
            #1;
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        idle(1);
        chk("bp_release_ready", int'(a.in_ready), 1);
        for (int i = 0; i < 8; i++) send(0, 2);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            send(0, gap[i]);
            if (i == 6) chk("gap_no_early_valid", int'(a.out_valid), 0);
            idle(1);
        end
        idle(1);

        for (int i = 0; i < 3; i++) send(0, 10);
        clear = 1'b1;
        send(0, 10);
        clear = 1'b0;
        model_reset(0);
        a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 1);
        idle(2);

        a.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 1);
        a.in_valid = 1'b0;
        chk("clr_hold_valid", int'(a.out_valid), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        void'(qa.pop_front());
        chk("clr_drop_valid", int'(a.out_valid), 0);
        chk("clr_drop_acc", int'(a.out_acc), 0);
        a.out_ready = 1'b1;

        for (int i = 0; i < 3; i++) send(0, 2);
        a.in_valid = 1'b0;
        chk("pre_rst_acc", int'(a.out_acc), 6);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_acc", int'(a.out_acc), 0);
        chk("async_rst_valid", int'(a.out_valid), 0);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in_ready", int'(a.in_ready), 1);
        for (int i = 0; i < 8; i++) send(0, 2);
        idle(3);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum output.
- Accepts a stream of sums over a valid/ready handshake and accumulates COUNT samples into an ACC_W-bit register.
- Presents each batch total with an overflow flag over a second valid/ready handshake.
- Serves as the batch/reduction stage after the adder in the datapath exercises.

Parameters:
- IN_W, 5, width of the incoming sum; matches the adder's 4-bit + carry output.
- ACC_W, 12, accumulator/result width; must be >= IN_W.
- COUNT, 8, samples per batch; must be >= 1. Counter width is $clog2(COUNT+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous batch abort; highest priority after reset.
- in_valid  input  1  in_sum is valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  IN_W  sum from upstream adder; unsigned.
- out_valid  output  1  out_acc/out_ovf hold a completed batch.
- out_ready  input  1  downstream takes the result.
- out_acc  output  ACC_W  batch total.
- out_ovf  output  1  a carry out of ACC_W occurred during this batch (sticky per batch).

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, async):
  - state=ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_ovf=0, in_ready=1 (after release).
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: acc <= acc + zero-extended in_sum, computed ACC_W+1 wide; ovf <= ovf | bit ACC_W; acc keeps the low ACC_W bits (wrap); cnt <= cnt+1.
  - If the accept makes cnt reach COUNT: next state HOLD.
  - No accept: all registers hold.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_acc=acc and out_ovf=ovf, stable while out_valid=1 and out_ready=0.
  - On out_ready=1: next state ACCUM; acc, cnt and ovf all cleared to 0.
  - in_valid is ignored in HOLD. A sample presented in the handoff cycle is not consumed; it is accepted the following cycle.
- Latency: out_valid rises on the clock edge that accepts the COUNT-th sample (visible the next cycle). Minimum batch period is COUNT+1 cycles.
- Throughput: one sample per cycle in ACCUM with in_valid held high.
- clear=1 (synchronous, either state):
  - next state ACCUM; acc=0, cnt=0, ovf=0.
  - Any held result is discarded without handshake.
  - An in_valid in the same cycle is not accumulated.
  - clear overrides out_ready and accept.
- COUNT=1: every accepted sample goes straight to HOLD.
- Output ports are driven from registers only (no combinational path from in_sum to out_acc).
- Reset mid-batch: partial sum lost, no out_valid.

Optional Feature:
- Macro: SUM_ACC_SATURATE_EN.
- Defined: when the add carries out of ACC_W, acc is set to all-ones and remains there for the rest of the batch (further adds keep it saturated). ovf is set as normal.
- Not defined: modulo-2^ACC_W wrap as specified above.
- Handshake, latency and ovf behaviour are identical in both builds.

Test Plan:
- Defaults, 8 back-to-back samples of 5'd30, out_ready=1 → out_valid one cycle after 8th accept, out_acc=240, out_ovf=0, then in_ready=1 next cycle.
- ACC_W=7, 8 samples of 5'd31 → out_acc=120 (248 mod 128), out_ovf=1; with SUM_ACC_SATURATE_EN → out_acc=127, out_ovf=1.
- Backpressure: batch of 1..8 (sum 36), out_ready=0 for 5 cycles → out_valid, out_acc=36 stable, in_ready=0 and in_valid samples not absorbed; raise out_ready → next batch starts at acc=0.
- Gapped input: in_valid toggling every other cycle, values 3,7,0,16,31,1,2,4 → out_acc=64 after 8th accept only.
- clear after 3 samples (values 10 each), then 8 samples of 1 → out_acc=8, out_ovf=0; clear in HOLD drops out_valid next cycle.
- rst_n pulled low asynchronously mid-batch (between edges) → outputs 0 immediately, in_ready=1 after release, fresh batch of 8×2 → out_acc=16.
